ltc2311_sample_scheduler: RTL

Sequencer that drives an LTC2311 reader block at a programmable sample rate and buffers its results. Generates one-cycle `read` requests from a free-running period timer or software single-shot, tracks each conversion through the reader's `busy`/`data_valid` handshake, and pushes samples into a FWFT FIFO drained by a valid/ready consumer. It sits between the register/DSP side and the ADC reader, and is the only agent issuing reads.

---
 rtl/ltc2311_pkg.sv | 13 +
 rtl/ltc2311_sample_fifo.sv | 57 +++++
 rtl/ltc2311_sample_scheduler.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/ltc2311_pkg.sv
// Shared types and constants for the LTC2311 sample scheduler slice.
package ltc2311_pkg;

  localparam int ADC_DATA_W     = 16;
  // Request-to-data_valid latency of the companion reader block.
  localparam int LTC2311_CYCLES = 21;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_DONE = 1'b1
  } sched_state_t;

endpackage

// File: rtl/ltc2311_sample_fifo.sv
// First-word-fall-through sample FIFO; head is visible on rdata whenever not empty.
module ltc2311_sample_fifo
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok;
  logic             pop_ok;

  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);

  // A push into a full FIFO only lands when the head leaves in the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/ltc2311_sample_scheduler.sv
// Issues LTC2311 reader requests from a period timer or single-shot and
// buffers returned samples for a valid/ready consumer.
module ltc2311_sample_scheduler
  import ltc2311_pkg::*;
#(
  parameter int PERIOD_W   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [PERIOD_W-1:0]           period,
  input  logic                          single_shot,
  input  logic                          clr_flags,
  output logic                          rd_read,
  input  logic                          rd_busy,
  input  logic                          rd_valid,
  input  logic [ADC_DATA_W-1:0]         rd_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [ADC_DATA_W-1:0]         m_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overrun,
  output logic                          timeout_err
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  // Period timer
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] cnt_cur;
  logic [PERIOD_W-1:0] reload_val;
  logic                load_q, load_d;
  logic                tick;

  // Request flag, controller and sticky flags
  logic                pending_q, pending_d;
  sched_state_t        state_q, state_d;
  logic                rd_read_q, rd_read_d;
  logic [WDW-1:0]      wd_q, wd_d;
  logic                overrun_q, overrun_d;
  logic                timeout_err_q, timeout_err_d;
  logic                issue;
  logic                push;
  logic                pop;
  logic                timeout_hit;
  logic                fifo_full;
  logic                fifo_empty;

  assign reload_val = (period == '0) ? '0 : period - PERIOD_W'(1);

  // load_q stands in for "counter holds period-1" right after reset, so the
  // reset value of the counter itself can stay a constant.
  assign cnt_cur = load_q ? reload_val : cnt_q;
  assign tick    = enable && (cnt_cur == '0);

  always_comb begin
    load_d = 1'b0;
    cnt_d  = cnt_cur;
    if (!enable || cnt_cur == '0) cnt_d = reload_val;
    else                          cnt_d = cnt_cur - PERIOD_W'(1);
  end

  assign issue = (state_q == IDLE) && pending_q && !rd_busy;

  // Consuming the flag wins over a coincident request, which is coalesced.
  always_comb begin
    pending_d = pending_q;
    if (issue)                    pending_d = 1'b0;
    else if (tick || single_shot) pending_d = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    rd_read_d   = 1'b0;
    wd_d        = wd_q;
    push        = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (issue) begin
          rd_read_d = 1'b1;
          wd_d      = '0;
          state_d   = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        wd_d = wd_q + WDW'(1);
        if (rd_valid) begin
          push    = 1'b1;
          state_d = IDLE;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop = m_valid && m_ready;

  always_comb begin
    overrun_d     = (push && fifo_full && !pop) || (overrun_q && !clr_flags);
    timeout_err_d = timeout_hit || (timeout_err_q && !clr_flags);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      rd_read_q <= 1'b0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      rd_read_q <= rd_read_d;
      wd_q      <= wd_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q         <= '0;
      load_q        <= 1'b1;
      pending_q     <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      load_q        <= load_d;
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  ltc2311_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ADC_DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (rd_data),
    .pop     (pop),
    .rdata   (m_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign m_valid     = !fifo_empty;
  assign rd_read     = rd_read_q;
  assign overrun     = overrun_q;
  assign timeout_err = timeout_err_q;

endmodule
